// File: rtl/rr_dec_arbiter.sv
// rr_dec_arbiter: 8-way round-robin arbiter with a one-hot decoded grant.
// Define ARB_TIMEOUT_EN to build in the grant-hold watchdog.
module rr_dec_arbiter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_vld,
   output logic       timeout
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [2:0] gnt_idx_q;
   logic [2:0] gnt_idx_d;
   logic [2:0] last_q;
   logic [2:0] last_d;
   logic       gnt_vld_q;
   logic       gnt_vld_d;

   logic [2:0] cand;
   logic [2:0] pick_idx;
   logic       pick_vld;
   logic       release_w;

`ifdef ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          timeout_q;
   logic          timeout_d;
   logic          tmo_hit;

   // Watchdog expires on the last allowed BUSY cycle.
   always_comb begin
      tmo_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
   end
`else
   localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
`endif

   // Round-robin search: first set request at last+1 upward, wrapping 7 -> 0.
   always_comb begin
      cand     = 3'd0;
      pick_idx = 3'd0;
      pick_vld = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cand = last_q + 3'd1 + 3'(i);
         if (!pick_vld && req[cand]) begin
            pick_idx = cand;
            pick_vld = 1'b1;
         end
      end
   end

   // Holder gives the resource back by done or by dropping its request.
   always_comb begin
      release_w = done | ~req[gnt_idx_q];
   end

   // Next-state and registered-output computation for the two-state FSM.
   always_comb begin
      state_d   = state_q;
      gnt_idx_d = gnt_idx_q;
      last_d    = last_q;
      gnt_vld_d = gnt_vld_q;
`ifdef ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d   = BUSY;
               gnt_idx_d = pick_idx;
               last_d    = pick_idx;
               gnt_vld_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
               cnt_d     = '0;
`endif
            end
         end
         BUSY: begin
            if (release_w) begin
               state_d   = IDLE;
               gnt_vld_d = 1'b0;
            end
`ifdef ARB_TIMEOUT_EN
            else if (tmo_hit) begin
               state_d   = IDLE;
               gnt_vld_d = 1'b0;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`endif
         end
         default: begin
            state_d   = IDLE;
            gnt_vld_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops any grant at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_idx_q <= 3'd0;
         last_q    <= 3'd7;
         gnt_vld_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt_q     <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         gnt_idx_q <= gnt_idx_d;
         last_q    <= last_d;
         gnt_vld_q <= gnt_vld_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   // One-hot grant: 3-to-8 decode of the index, gated by valid.
   always_comb begin
      gnt = 8'h00;
      if (gnt_vld_q) begin
         gnt = 8'h01 << gnt_idx_q;
      end
   end

   assign gnt_idx = gnt_idx_q;
   assign gnt_vld = gnt_vld_q;

`ifdef ARB_TIMEOUT_EN
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// tb_rr_dec_arbiter: directed vectors for rr_dec_arbiter.
// Expectations adapt when ARB_TIMEOUT_EN is defined.
module tb_rr_dec_arbiter;

   localparam int TMO = 16;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_vld;
   logic       timeout;

   int n_chk;
   int n_err;

   rr_dec_arbiter #(
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .done   (done),
      .gnt    (gnt),
      .gnt_idx(gnt_idx),
      .gnt_vld(gnt_vld),
      .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req  = 8'h00;
      done = 1'b0;
      rst  = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   logic [7:0] exp_g;

   initial begin
      n_chk = 0;
      n_err = 0;
      rst   = 1'b1;
      req   = 8'h00;
      done  = 1'b0;
      tick();
      tick();
      chk("rst_gnt", 32'(gnt), 32'h00);
      chk("rst_vld", 32'(gnt_vld), 32'h0);
      chk("rst_idx", 32'(gnt_idx), 32'h0);
      chk("rst_tmo", 32'(timeout), 32'h0);
      rst = 1'b0;
      tick();
      chk("idle_noreq_vld", 32'(gnt_vld), 32'h0);
      chk("idle_noreq_gnt", 32'(gnt), 32'h00);

      // single request, then done
      req = 8'h01;
      tick();
      chk("r28_vld", 32'(gnt_vld), 32'h1);
      chk("r28_gnt", 32'(gnt), 32'h01);
      chk("r28_idx", 32'(gnt_idx), 32'h0);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("r28_rel", 32'(gnt), 32'h00);

      // full rotation with all requesters active
      do_reset();
      req = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         tick();
         exp_g = 8'h01 << (i % 8);
         chk("rot_gnt", 32'(gnt), 32'(exp_g));
         chk("rot_vld", 32'(gnt_vld), 32'h1);
         done = 1'b1;
         tick();
         done = 1'b0;
         chk("rot_idle", 32'(gnt), 32'h00);
      end
      req = 8'h00;

      // wrap from idx 5 to idx 0, then back to 5
      do_reset();
      req = 8'h20;
      tick();
      chk("wr_g5", 32'(gnt_idx), 32'h5);
      req  = 8'h21;
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("wr_idle", 32'(gnt_vld), 32'h0);
      tick();
      chk("wr_g0", 32'(gnt), 32'h01);
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      chk("wr_g5b", 32'(gnt), 32'h20);
      done = 1'b1;
      tick();
      done = 1'b0;

      // no preemption; release by dropping the request
      do_reset();
      req = 8'h04;
      tick();
      chk("np_g2", 32'(gnt), 32'h04);
      req = 8'h44;
      tick();
      chk("np_hold", 32'(gnt), 32'h04);
      req = 8'h40;
      tick();
      chk("np_drop_vld", 32'(gnt_vld), 32'h0);
      chk("np_drop_gnt", 32'(gnt), 32'h00);
      chk("np_idx_hold", 32'(gnt_idx), 32'h2);
      tick();
      chk("np_g6", 32'(gnt), 32'h40);
      chk("np_i6", 32'(gnt_idx), 32'h6);
      req = 8'h00;
      tick();

      // asynchronous reset in the middle of a grant
      do_reset();
      req = 8'h02;
      tick();
      chk("ar_g1", 32'(gnt), 32'h02);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_drop_gnt", 32'(gnt), 32'h00);
      chk("ar_drop_vld", 32'(gnt_vld), 32'h0);
      req = 8'h80;
      tick();
      chk("ar_held", 32'(gnt_vld), 32'h0);
      rst = 1'b0;
      tick();
      chk("ar_g7", 32'(gnt), 32'h80);
      chk("ar_i7", 32'(gnt_idx), 32'h7);

      // single requester granted again and again
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("rep_idle", 32'(gnt_vld), 32'h0);
      tick();
      chk("rep_g7", 32'(gnt), 32'h80);
      done = 1'b1;
      tick();
      done = 1'b0;
      req = 8'h00;

      // long hold: watchdog revokes, or grant is held forever
      do_reset();
      req = 8'h04;
      for (int i = 0; i < TMO; i++) begin
         tick();
         chk("wd_busy_vld", 32'(gnt_vld), 32'h1);
         chk("wd_busy_tmo", 32'(timeout), 32'h0);
      end
      tick();
`ifdef ARB_TIMEOUT_EN
      chk("wd_exp_vld", 32'(gnt_vld), 32'h0);
      chk("wd_exp_tmo", 32'(timeout), 32'h1);
      tick();
      chk("wd_regnt_vld", 32'(gnt_vld), 32'h1);
      chk("wd_regnt_tmo", 32'(timeout), 32'h0);
`else
      for (int i = 0; i < 20; i++) begin
         chk("wd_hold_vld", 32'(gnt_vld), 32'h1);
         chk("wd_hold_tmo", 32'(timeout), 32'h0);
         tick();
      end
`endif

      // done coincides with the watchdog expiry: plain release
      do_reset();
      req = 8'h04;
      for (int i = 0; i < TMO; i++) begin
         tick();
      end
      chk("co_busy", 32'(gnt), 32'h04);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("co_vld", 32'(gnt_vld), 32'h0);
      chk("co_tmo", 32'(timeout), 32'h0);
      req = 8'h00;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/rr_dec_arbiter.md
RR_DEC_ARBITER -- requirements
Module: rr_dec_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum grant hold length in clocks (used only when the timeout feature is compiled in).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 8 bits: one request line per requester, level-sensitive.
REQ-005 The block SHALL have port done, input, 1 bit: the current grant holder releases the resource.
REQ-006 The block SHALL have port gnt, output, 8 bits: one-hot grant, produced by 3-to-8 decode of gnt_idx gated by gnt_vld.
REQ-007 The block SHALL have port gnt_idx, output, 3 bits: index of the granted requester.
REQ-008 The block SHALL have port gnt_vld, output, 1 bit: a grant is active.
REQ-009 The block SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is revoked by the watchdog.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE (no grant) and BUSY (grant held).
REQ-011 In IDLE with req != 0, the block SHALL enter BUSY on the next edge with gnt_idx = the first set req bit searching upward from (last+1) mod 8, wrapping 7 -> 0.
REQ-012 "last" SHALL be a 3-bit register holding the most recently granted index; it SHALL update on every grant.
REQ-013 In IDLE with req == 0, the block SHALL stay in IDLE with gnt_vld = 0 and gnt = 8'h00.
REQ-014 Grant latency SHALL be exactly one clock from req sampled in IDLE to gnt_vld = 1.
REQ-015 In BUSY, gnt = 8'b1 << gnt_idx; exactly one gnt bit SHALL be high.
REQ-016 In BUSY, done = 1 or req[gnt_idx] = 0 SHALL return the block to IDLE on the next edge, deasserting gnt_vld and gnt.
REQ-017 After release, the block SHALL spend at least one cycle in IDLE before issuing the next grant (no back-to-back grants).
REQ-018 A requester whose req bit is set while another holds the grant SHALL NOT preempt it; its request is arbitrated on the next IDLE cycle.
REQ-019 gnt_idx SHALL hold its value while in IDLE; gnt remains 0 regardless of gnt_idx.
REQ-020 A single active requester SHALL be granted repeatedly (grant, release, IDLE, grant) without starvation logic blocking it.

Reset
REQ-021 On rst = 1, asynchronously: state = IDLE, gnt = 8'h00, gnt_vld = 0, gnt_idx = 3'd0, timeout = 0, watchdog counter = 0.
REQ-022 "last" SHALL reset to 3'd7 so the first search starts at index 0.
REQ-023 Reset asserted during BUSY SHALL immediately drop the grant; no grant SHALL be issued until the first edge after rst deasserts.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN SHALL compile the grant watchdog in or out.
REQ-025 With ARB_TIMEOUT_EN defined: a counter cleared on grant increments each BUSY cycle; when the grant has been held TIMEOUT_CYCLES cycles without release, the block SHALL return to IDLE on the next edge and pulse timeout = 1 for that one cycle.
REQ-026 If done and the watchdog expiry coincide, the block SHALL treat it as a normal release with timeout = 0.
REQ-027 Without ARB_TIMEOUT_EN: no counter SHALL exist, timeout SHALL be tied 0, and grants are held indefinitely until release.

Verification
REQ-028 Reset, then req = 8'h01 -> gnt_vld = 1, gnt = 8'h01, gnt_idx = 0 one clock later; done pulse -> gnt = 8'h00 next clock.
REQ-029 req = 8'hFF held, done pulsed each grant -> gnt sequence 01,02,04,08,10,20,40,80,01 (IDLE cycle between each).
REQ-030 Grant to idx 5, last = 5, then req = 8'h21 -> next grant idx 0 (wrap), then idx 5.
REQ-031 Grant held on idx 2, req[2] dropped with done = 0 -> gnt_vld = 0 next clock; req[6] set during BUSY is granted only after the IDLE cycle.
REQ-032 rst pulsed mid-BUSY (between edges) -> gnt = 8'h00 immediately; after deassert with req = 8'h80 -> grant idx 7.
REQ-033 With ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, req = 8'h04 held, no done -> grant revoked after 16 BUSY cycles with a one-cycle timeout pulse; without macro -> grant never revoked and timeout stays 0.
